// File: rtl/mem_read_skew_ctrl_if.sv
// Handshake and per-bank read bus between a tile sequencer and mem_read_skew_ctrl.
// The master side starts a pass and applies back-pressure; the slave side drives the banks.
interface mem_read_skew_ctrl_if #(
    parameter int N      = 3,
    parameter int ADDR_W = 4
);
    logic                         start;
    logic                         hold;
    logic                         busy;
    logic                         done;
    logic [N-1:0][ADDR_W-1:0]     rd_addr_bram;
    logic [N-1:0]                 rd_en_bram;

    modport master (
        output start, hold,
        input  busy, done, rd_addr_bram, rd_en_bram
    );

    modport slave (
        input  start, hold,
        output busy, done, rd_addr_bram, rd_en_bram
    );
endinterface

// File: rtl/mem_read_skew_ctrl.sv
// Skewed BRAM read controller: sequences one operand tile into bank 0, then feeds each
// later bank through a SKEW-deep delay so reads line up with the systolic wavefront.
module mem_read_skew_ctrl #(
    parameter int N    = 3,
    parameter int M    = 6,
    parameter int SKEW = 1,
    localparam int DEPTH  = M * M / N,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_read_skew_ctrl_if.slave   bus
);
    // Stage 0 is bank 0; bank x taps stage x*SKEW of one continuous shift chain.
    localparam int CHAIN      = (N - 1) * SKEW + 1;
    localparam int DRAIN_CYC  = (N - 1) * SKEW;
    localparam int DRAIN_W    = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
    localparam int DRAIN_INIT = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state;
    logic                busy_q;
    logic                done_q;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                en_sr   [CHAIN];
    logic [ADDR_W-1:0]   addr_sr [CHAIN];

    // NOTE: the skew chain is reset along with the FSM so a mid-run reset leaves no
    // stale enables in flight; it is a handful of flops, not a RAM, so this is cheap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drain_cnt <= '0;
            for (int i = 0; i < CHAIN; i++) begin
                en_sr[i]   <= 1'b0;
                addr_sr[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let the chain shift in one edge without
            // stage i seeing the value stage i-1 receives on this same edge.
            done_q <= 1'b0;
            for (int i = 1; i < CHAIN; i++) begin
                en_sr[i]   <= en_sr[i-1];
                addr_sr[i] <= addr_sr[i-1];
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= RUN;
                        busy_q     <= 1'b1;
                        en_sr[0]   <= 1'b1;
                        addr_sr[0] <= '0;
                    end
                end
                RUN: begin
                    // Bank 0's address register doubles as the tile counter; it
                    // keeps the last issued address through hold bubbles.
                    if (en_sr[0] && addr_sr[0] == LAST_ADDR) begin
                        en_sr[0] <= 1'b0;
                        if (N > 1) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_W'(DRAIN_INIT);
                        end else begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end else if (bus.hold) begin
                        en_sr[0] <= 1'b0;
                    end else begin
                        en_sr[0]   <= 1'b1;
                        addr_sr[0] <= addr_sr[0] + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int x = 0; x < N; x++) begin
            bus.rd_en_bram[x]   = en_sr[x*SKEW];
            bus.rd_addr_bram[x] = addr_sr[x*SKEW];
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
